// File: rtl/encoder_read_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_read_sched_if
//  Description : Request / completion bundle between the angle-read scheduler
//                and the AS5600 I2C angle-read engine.
//                  i2c_req_n     : scheduler -> engine, low requests reads
//                                  (wired to the engine's angle_done input)
//                  i2c_rd_done   : engine -> scheduler, read-done level
//                  i2c_raw_angle : engine -> scheduler, 12-bit raw angle
//                master modport : scheduler side
//                slave  modport : engine side
//  Revision    : 1.0  initial release
// ============================================================================
interface encoder_read_sched_if;
    logic        i2c_req_n;
    logic        i2c_rd_done;
    logic [11:0] i2c_raw_angle;

    modport master (
        output i2c_req_n,
        input  i2c_rd_done,
        input  i2c_raw_angle
    );

    modport slave (
        input  i2c_req_n,
        output i2c_rd_done,
        output i2c_raw_angle
    );
endinterface
`default_nettype wire

// File: rtl/encoder_read_sched.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_read_sched
//  Description : Sequences periodic angle reads from the AS5600 I2C engine of
//                one swerve steering module. Issues a request every rd_period
//                clocks (or as fast as the transaction allows), supervises it
//                with a timeout, captures the raw angle and derives the
//                wrapped error against target_angle.
//  Ports       : clock, reset_n      clock / asynchronous active-low reset
//                enable              scheduling enable
//                rd_period[15:0]     clocks between request starts (0 acts as 1)
//                target_angle[11:0]  target raw angle
//                err_clr             clears timeout_err
//                i2c (master)        req_n / rd_done / raw_angle to the engine
//                angle[11:0]         last captured angle
//                angle_valid         one-clock pulse per capture
//                angle_err[11:0]     signed target - angle, wrapped
//                at_target           |angle_err| <= TOL
//                timeout_err         sticky timeout flag
//                read_count[7:0]     successful captures, wrapping
//  Revision    : 1.0  initial release
// ============================================================================
module encoder_read_sched #(
    parameter int          TIMEOUT = 20000,
    parameter logic [11:0] TOL     = 12'd8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [15:0]           rd_period,
    input  logic [11:0]           target_angle,
    input  logic                  err_clr,
    encoder_read_sched_if.master  i2c,
    output logic [11:0]           angle,
    output logic                  angle_valid,
    output logic [11:0]           angle_err,
    output logic                  at_target,
    output logic                  timeout_err,
    output logic [7:0]            read_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_TCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TCNT_W-1:0] c_TCNT_LAST = c_TCNT_W'(TIMEOUT - 1);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_REQUEST   = 3'd1;
    localparam logic [2:0] c_ST_WAIT_DONE = 3'd2;
    localparam logic [2:0] c_ST_CAPTURE   = 3'd3;
    localparam logic [2:0] c_ST_HOLDOFF   = 3'd4;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]          state_q,       state_d;
    logic [15:0]         period_cnt_q,  period_cnt_d;
    logic [c_TCNT_W-1:0] tmo_cnt_q,     tmo_cnt_d;
    logic                rd_done_q,     rd_done_d;
    logic                req_n_q,       req_n_d;
    logic [11:0]         angle_q,       angle_d;
    logic                angle_valid_q, angle_valid_d;
    logic [11:0]         angle_err_q,   angle_err_d;
    logic                at_target_q,   at_target_d;
    logic                timeout_err_q, timeout_err_d;
    logic [7:0]          read_count_q,  read_count_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        w_rd_done_rise;
    logic        w_tmo_hit;
    logic        w_tmo_set;
    logic [15:0] w_period_thr;
    logic        w_period_due;
    logic [11:0] w_diff;
    logic [11:0] w_diff_mag;

    // The engine holds rd_done as a level; only its rising edge completes a
    // transaction, so a long level yields a single capture.
    assign w_rd_done_rise = i2c.i2c_rd_done & ~rd_done_q;
    assign w_tmo_hit      = (tmo_cnt_q == c_TCNT_LAST);

    // Completion on the very clock the count expires still counts as a read.
    assign w_tmo_set      = (state_q == c_ST_WAIT_DONE) & w_tmo_hit & ~w_rd_done_rise;

    // A period of 0 behaves as 1: the request may follow after one HOLDOFF clock.
    assign w_period_thr   = (rd_period == 16'd0) ? 16'd0 : (rd_period - 16'd1);
    assign w_period_due   = (period_cnt_q >= w_period_thr);

    // Modulo-4096 difference read as 12-bit two's complement. The magnitude is
    // taken as an unsigned 12-bit value so that -2048 yields 2048 (12'h800).
    assign w_diff         = target_angle - i2c.i2c_raw_angle;
    assign w_diff_mag     = w_diff[11] ? (~w_diff + 12'd1) : w_diff;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (enable) begin
                    state_d = c_ST_REQUEST;
                end
            end
            c_ST_REQUEST: begin
                state_d = c_ST_WAIT_DONE;
            end
            c_ST_WAIT_DONE: begin
                // enable is deliberately ignored here: an issued read always
                // runs to completion or timeout.
                if (w_rd_done_rise) begin
                    state_d = c_ST_CAPTURE;
                end else if (w_tmo_hit) begin
                    state_d = c_ST_HOLDOFF;
                end
            end
            c_ST_CAPTURE: begin
                state_d = c_ST_HOLDOFF;
            end
            c_ST_HOLDOFF: begin
                if (!enable) begin
                    state_d = c_ST_IDLE;
                end else if (w_period_due) begin
                    state_d = c_ST_REQUEST;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------------
    always_comb begin
        // The period counter reads 0 throughout REQUEST and counts from there,
        // so the HOLDOFF test against rd_period-1 spaces REQUEST entries (and
        // hence req_n falls) exactly rd_period clocks apart. It saturates so a
        // long HOLDOFF never wraps back below the threshold.
        period_cnt_d = period_cnt_q;
        if (state_d == c_ST_REQUEST) begin
            period_cnt_d = 16'd0;
        end else if ((state_q != c_ST_IDLE) && (period_cnt_q != 16'hFFFF)) begin
            period_cnt_d = period_cnt_q + 16'd1;
        end

        // The timeout counter is 0 on the first WAIT_DONE clock, i.e. the
        // first clock req_n is seen low, so the hit falls TIMEOUT clocks after
        // the request.
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == c_ST_REQUEST) begin
            tmo_cnt_d = '0;
        end else if ((state_q == c_ST_WAIT_DONE) && !w_tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q + c_TCNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    always_comb begin
        rd_done_d     = i2c.i2c_rd_done;

        // Low while the request is outstanding; released on the CAPTURE clock
        // or immediately at the timeout edge.
        req_n_d       = ~((state_q == c_ST_REQUEST) |
                          ((state_q == c_ST_WAIT_DONE) & ~w_tmo_set));

        angle_d       = angle_q;
        angle_err_d   = angle_err_q;
        at_target_d   = at_target_q;
        read_count_d  = read_count_q;
        angle_valid_d = 1'b0;

        if (state_q == c_ST_CAPTURE) begin
            angle_d       = i2c.i2c_raw_angle;
            angle_err_d   = w_diff;
            at_target_d   = (w_diff_mag <= TOL);
            read_count_d  = read_count_q + 8'd1;
            angle_valid_d = 1'b1;
        end

        // A timeout in the same clock as err_clr leaves the flag set.
        timeout_err_d = timeout_err_q;
        if (w_tmo_set) begin
            timeout_err_d = 1'b1;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Flops
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= c_ST_IDLE;
            period_cnt_q  <= 16'd0;
            tmo_cnt_q     <= '0;
            rd_done_q     <= 1'b0;
            req_n_q       <= 1'b1;
            angle_q       <= 12'd0;
            angle_valid_q <= 1'b0;
            angle_err_q   <= 12'd0;
            at_target_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            read_count_q  <= 8'd0;
        end else begin
            state_q       <= state_d;
            period_cnt_q  <= period_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            rd_done_q     <= rd_done_d;
            req_n_q       <= req_n_d;
            angle_q       <= angle_d;
            angle_valid_q <= angle_valid_d;
            angle_err_q   <= angle_err_d;
            at_target_q   <= at_target_d;
            timeout_err_q <= timeout_err_d;
            read_count_q  <= read_count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign i2c.i2c_req_n = req_n_q;
    assign angle         = angle_q;
    assign angle_valid   = angle_valid_q;
    assign angle_err     = angle_err_q;
    assign at_target     = at_target_q;
    assign timeout_err   = timeout_err_q;
    assign read_count    = read_count_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder_read_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder_read_sched
//  Description : Self-checking bench for encoder_read_sched. Plays the I2C
//                engine, drives directed and randomized reads and compares
//                the scheduler's outputs against arithmetic expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_encoder_read_sched;

    localparam int c_TIMEOUT = 100;
    localparam int c_TOL     = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] rd_period;
    logic [11:0] target_angle;
    logic        err_clr;
    logic [11:0] angle;
    logic        angle_valid;
    logic [11:0] angle_err;
    logic        at_target;
    logic        timeout_err;
    logic [7:0]  read_count;

    encoder_read_sched_if bus ();

    encoder_read_sched #(
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .rd_period    (rd_period),
        .target_angle (target_angle),
        .err_clr      (err_clr),
        .i2c          (bus),
        .angle        (angle),
        .angle_valid  (angle_valid),
        .angle_err    (angle_err),
        .at_target    (at_target),
        .timeout_err  (timeout_err),
        .read_count   (read_count)
    );

    always #5 clock = ~clock;

    // Number of rising edges so far; read on falling edges only.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks    = 0;
    int errors    = 0;
    int exp_count = 0;

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: signed wrapped difference of two angles on a 4096-count circle.
    function automatic int model_err(input int t, input int a);
        int d;
        d = (t - a) % 4096;
        if (d < 0) d += 4096;
        if (d >= 2048) d -= 4096;
        return d;
    endfunction

    task automatic wait_req_low(input int bound, output int t_fall);
        int n;
        n = 0;
        while (bus.i2c_req_n !== 1'b0 && n < bound) begin
            step(1);
            n++;
        end
        t_fall = cyc;
        check("req_fall", 32'(bus.i2c_req_n), 32'd0);
    endtask

    // Engine side of one transaction, entered with the request outstanding.
    task automatic do_read(input logic [11:0] raw, input int delay, input int hold,
                           output int t_valid);
        int          d;
        int          mag;
        logic [11:0] e;
        int          last;
        step(delay);
        bus.i2c_raw_angle = raw;
        bus.i2c_rd_done   = 1'b1;
        d   = model_err(int'(target_angle), int'(raw));
        mag = (d < 0) ? -d : d;
        e   = d[11:0];
        last = (hold > 3) ? hold : 3;
        t_valid = 0;
        for (int i = 1; i <= last; i++) begin
            step(1);
            if (i == hold) bus.i2c_rd_done = 1'b0;
            if (i == 1) begin
                check("valid_early", 32'(angle_valid), 32'd0);
                check("req_still_low", 32'(bus.i2c_req_n), 32'd0);
            end
            if (i == 2) begin
                exp_count = (exp_count + 1) % 256;
                check("valid_pulse", 32'(angle_valid), 32'd1);
                check("angle", 32'(angle), 32'(raw));
                check("read_count", 32'(read_count), 32'(exp_count));
                check("angle_err", 32'(angle_err), 32'(e));
                check("at_target", 32'(at_target), (mag <= c_TOL) ? 32'd1 : 32'd0);
                check("req_released", 32'(bus.i2c_req_n), 32'd1);
                t_valid = cyc;
            end
            if (i == 3) check("valid_one_clock", 32'(angle_valid), 32'd0);
        end
    endtask

    initial begin
        int          t0, t1, t2, tv, tf, t_en, flag;
        int          new_period;
        int          tgt_tab[4];
        int          raw_tab[4];
        logic [11:0] r;

        tgt_tab = '{5, 4090, 0, 4090};
        raw_tab = '{4090, 4085, 2048, 5};

        reset_n           = 1'b0;
        enable            = 1'b0;
        rd_period         = 16'd1000;
        target_angle      = 12'd0;
        err_clr           = 1'b0;
        bus.i2c_rd_done   = 1'b0;
        bus.i2c_raw_angle = 12'd0;

        // ---------------- reset values ----------------
        step(2);
        check("rst_req_n", 32'(bus.i2c_req_n), 32'd1);
        check("rst_angle", 32'(angle), 32'd0);
        check("rst_valid", 32'(angle_valid), 32'd0);
        check("rst_err", 32'(angle_err), 32'd0);
        check("rst_at_target", 32'(at_target), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_count", 32'(read_count), 32'd0);
        reset_n = 1'b1;
        step(2);

        // ---------------- basic read, period 1000 ----------------
        target_angle = 12'($urandom_range(0, 4095));
        t_en   = cyc;
        enable = 1'b1;
        wait_req_low(10, t0);
        check("first_req_latency", 32'(t0 - t_en), 32'd2);
        do_read(12'h123, $urandom_range(0, 20), 4, tv);
        wait_req_low(1100, t1);
        check("period_1000", 32'(t1 - t0), 32'd1000);
        r = 12'($urandom_range(0, 4095));
        target_angle = 12'($urandom_range(0, 4095));
        do_read(r, $urandom_range(0, 30), $urandom_range(1, 6), tv);

        // period change while in HOLDOFF applies to the next comparison
        new_period = $urandom_range(100, 800);
        rd_period  = 16'(new_period);
        wait_req_low(900, t2);
        check("period_changed", 32'(t2 - t1), 32'(new_period));

        // ---------------- enable dropped mid-WAIT_DONE ----------------
        enable = 1'b0;
        r = 12'($urandom_range(0, 4095));
        do_read(r, $urandom_range(2, 15), $urandom_range(1, 5), tv);
        flag = 0;
        repeat (200) begin
            step(1);
            if (bus.i2c_req_n !== 1'b1) flag = 1;
        end
        check("no_req_after_disable", 32'(flag), 32'd0);

        // ---------------- short period: wrap cases, then random ----------------
        rd_period = 16'd0;
        enable    = 1'b1;
        wait_req_low(10, t0);
        for (int i = 0; i < 260; i++) begin
            if (i < 4) begin
                target_angle = 12'(tgt_tab[i]);
                r            = 12'(raw_tab[i]);
            end else begin
                target_angle = 12'($urandom_range(0, 4095));
                r            = 12'($urandom_range(0, 4095));
                // bias some reads close to the target to exercise the tolerance edge
                if (i % 3 == 0) r = target_angle + 12'($urandom_range(0, 20)) - 12'd10;
            end
            if (i == 259) enable = 1'b0;
            do_read(r, $urandom_range(0, 2), $urandom_range(1, 3), tv);
            if (i < 259) begin
                wait_req_low(10, tf);
                check("short_gap", 32'(tf - tv), 32'd2);
            end
        end
        step(5);

        // ---------------- timeout ----------------
        rd_period = 16'd300;
        enable    = 1'b1;
        wait_req_low(10, t0);
        step(c_TIMEOUT - 1);
        check("tmo_not_yet", 32'(timeout_err), 32'd0);
        check("tmo_req_low", 32'(bus.i2c_req_n), 32'd0);
        step(1);
        check("tmo_set", 32'(timeout_err), 32'd1);
        check("tmo_req_high", 32'(bus.i2c_req_n), 32'd1);

        // a late completion must be ignored
        step(2);
        bus.i2c_raw_angle = 12'($urandom_range(0, 4095));
        bus.i2c_rd_done   = 1'b1;
        flag = 0;
        repeat (4) begin
            step(1);
            if (angle_valid !== 1'b0) flag = 1;
        end
        bus.i2c_rd_done = 1'b0;
        check("late_no_capture", 32'(flag), 32'd0);
        check("late_count", 32'(read_count), 32'(exp_count));

        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("err_clr", 32'(timeout_err), 32'd0);

        wait_req_low(400, t1);
        check("period_after_tmo", 32'(t1 - t0), 32'd300);
        step(c_TIMEOUT - 1);
        err_clr = 1'b1;
        step(1);
        check("tmo_set_wins", 32'(timeout_err), 32'd1);
        err_clr = 1'b0;
        enable  = 1'b0;
        step(3);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;

        // ---------------- asynchronous reset in WAIT_DONE ----------------
        rd_period = 16'd0;
        enable    = 1'b1;
        wait_req_low(10, t0);
        step(3);
        #2 reset_n = 1'b0;
        #1;
        check("arst_req_n", 32'(bus.i2c_req_n), 32'd1);
        check("arst_angle", 32'(angle), 32'd0);
        check("arst_valid", 32'(angle_valid), 32'd0);
        check("arst_err", 32'(angle_err), 32'd0);
        check("arst_at_target", 32'(at_target), 32'd0);
        check("arst_timeout", 32'(timeout_err), 32'd0);
        check("arst_count", 32'(read_count), 32'd0);
        exp_count = 0;
        step(1);
        t_en    = cyc;
        reset_n = 1'b1;
        wait_req_low(10, t0);
        check("restart_latency", 32'(t0 - t_en), 32'd2);
        enable = 1'b0;
        r = 12'($urandom_range(0, 4095));
        do_read(r, $urandom_range(0, 10), 2, tv);
        step(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/encoder_read_sched.md
# encoder_read_sched

Scheduler that sequences the AS5600 I2C angle-read engine for one swerve steering module. It issues read requests at a programmable period, watches for completion or timeout, and captures each raw angle. It also computes the wrapped error against a target angle, flagging when the module is within tolerance. It sits between the PWM steering controller and the I2C engine and drives the engine's active-low `angle_done` input.

## Interface
- `TIMEOUT`, default 20000: clocks allowed from request assertion to `rd_done` before a timeout.
- `TOL`, default 12'd8: at-target tolerance in raw counts.
- `clock`  in  1  main clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  scheduling enable.
- `rd_period`  in  16  clocks between successive request starts; 0 is treated as 1.
- `target_angle`  in  12  target raw angle, 0..4095.
- `err_clr`  in  1  clears `timeout_err`.
- `i2c_rd_done`  in  1  engine read-done indication; a level that may stay high for several clocks.
- `i2c_raw_angle`  in  12  engine angle result.
- `i2c_req_n`  out  1  connects to the engine's `angle_done`; low requests reads.
- `angle`  out  12  last captured angle.
- `angle_valid`  out  1  one-clock pulse on each capture.
- `angle_err`  out  12  signed, `target_angle - angle` wrapped to -2048..+2047.
- `at_target`  out  1  |`angle_err`| <= `TOL`.
- `timeout_err`  out  1  sticky timeout flag.
- `read_count`  out  8  successful captures, wraps 255->0.

## Operation
- States: IDLE, REQUEST, WAIT_DONE, CAPTURE, HOLDOFF.
- IDLE:
  - `i2c_req_n`=1.
  - `enable`=1 -> REQUEST.
- REQUEST (1 clock):
  - Drive `i2c_req_n`=0.
  - Clear the period and timeout counters.
  - -> WAIT_DONE.
- WAIT_DONE:
  - `i2c_req_n` stays 0.
  - Period and timeout counters increment every clock.
  - Rising edge of `i2c_rd_done`, detected against a registered copy, -> CAPTURE.
  - Timeout counter reaching `TIMEOUT`-1 without an edge -> set `timeout_err`, then HOLDOFF.
- CAPTURE (1 clock):
  - `i2c_req_n`=1.
  - Register `angle`<=`i2c_raw_angle`.
  - Pulse `angle_valid`.
  - Increment `read_count`.
  - Update `angle_err` and `at_target`.
  - -> HOLDOFF.
- HOLDOFF:
  - `i2c_req_n`=1; the period counter keeps running.
  - When the period count is >= `rd_period`-1 and `enable`=1 -> REQUEST.
  - `enable`=0 -> IDLE.
  - Stay in HOLDOFF for at least 1 clock, so the engine sees `angle_done` high in its PAUSE state.
- Error arithmetic:
  - d = (`target_angle` - `angle`) mod 4096, as a 12-bit two's-complement value.
  - e.g. target 5, angle 4090 -> +11; target 4090, angle 5 -> -11; difference 2048 -> -2048.
  - `at_target` uses the magnitude of d; |-2048| = 2048.
- `enable` dropping in REQUEST or WAIT_DONE does not abort the transaction. It completes, or times out, then the block goes to IDLE from HOLDOFF.
- `i2c_rd_done` edges outside WAIT_DONE, e.g. a late completion after a timeout, are ignored: no capture, no count.
- A multi-cycle `i2c_rd_done` level produces exactly one capture.
- Timeout set and `err_clr` in the same clock: set wins.
- `rd_period` is sampled continuously. A change takes effect on the next HOLDOFF comparison.

## Timing
- Reset values:
  - `i2c_req_n`=1.
  - `angle`=0, `angle_valid`=0, `angle_err`=0, `at_target`=0.
  - `timeout_err`=0, `read_count`=0.
  - State IDLE, all counters 0.
- Reset mid-transaction forces the reset values immediately (asynchronous). The engine shares `reset_n`.
- `enable` rising in IDLE at clock edge N: `i2c_req_n` goes low after edge N+1.
- `i2c_rd_done` first sampled high at edge N in WAIT_DONE:
  - `angle`, `angle_err`, `at_target`, `read_count` and `i2c_req_n`=1 are all visible after edge N+1.
  - `angle_valid` is high for exactly that one cycle.
- Request-start spacing is max(`rd_period`, transaction time + 2) clocks.
- A timeout asserts `timeout_err` and `i2c_req_n`=1 after the edge where the count equals `TIMEOUT`-1.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Basic read: `enable`=1, `rd_period`=1000, model returns 12'h123 with `rd_done` high for 4 clocks -> one `angle_valid` pulse, `angle`=12'h123, `read_count`=1, next `i2c_req_n` fall exactly 1000 clocks after the first.
- Wrap error: target 5, returned 4090 -> `angle_err`=+11, `at_target`=0. Target 4090, returned 4085 -> `angle_err`=+5, `at_target`=1.
- Timeout: model never asserts `rd_done`, `TIMEOUT`=100 -> `timeout_err`=1 and `i2c_req_n`=1 at request+100. A late `rd_done` causes no capture. `err_clr` clears the flag; `err_clr` in the same clock as a timeout leaves it set.
- `enable` dropped mid-WAIT_DONE -> transaction captured normally, then IDLE, with no further `i2c_req_n` fall.
- Short period: `rd_period`=0 -> back-to-back requests with exactly 1 HOLDOFF clock between the capture and the next `i2c_req_n` fall.
- Reset asserted in WAIT_DONE -> all outputs at reset values immediately. After release with `enable`=1, the read sequence restarts from IDLE.
